noc_output_allocator: RTL
=========================

# noc_output_allocator

Per-output-port switch allocator and credit tracker for the NoC router. It shares one router output port between the `NUM_INPUTS` input buffers using round-robin arbitration. A grant is held for a whole wormhole packet, from the first transferred flit through the flit flagged as tail. Flits are issued only while the downstream buffer has credit. One instance sits in front of each output port's crossbar select, in the `clk_noc` domain.

## Interface
Parameters:
- `NUM_INPUTS`, 5: number of requesting input ports; index 0 is the local injection port.
- `FLIT_BUFFER_DEPTH`, 4: downstream input-buffer depth, in flits; this is the initial credit count.
- `CREDIT_WIDTH`, `$clog2(FLIT_BUFFER_DEPTH+1)`: width of the credit counter.
- `SEL_WIDTH`, `$clog2(NUM_INPUTS)`: width of the crossbar select.

Ports:
- `clk_noc`, in, 1: the single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req`, in, `NUM_INPUTS`: bit i is set when input i has a head-of-queue flit routed to this output.
- `req_is_tail`, in, `NUM_INPUTS`: bit i is set when input i's head-of-queue flit is a tail.
- `credit_in`, in, 1: one pulse returns one downstream credit.
- `grant`, out, `NUM_INPUTS`: one-hot or zero; input i dequeues a flit this cycle.
- `sel`, out, `SEL_WIDTH`: crossbar select, equal to the index of the granted input. Holds its last value when there is no grant.
- `send_out`, out, 1: a flit leaves on this output this cycle (`|grant`).
- `credits`, out, `CREDIT_WIDTH`: registered credit count.
- `locked`, out, 1: state is LOCKED.
- `credit_err`, out, 1: sticky flag for credit overflow.

## Operation
- Registered state:
  - `state` ∈ {IDLE, LOCKED}
  - `owner` (`SEL_WIDTH`)
  - `rr_ptr` (`SEL_WIDTH`): last winner
  - `credits`
  - `credit_err`
- Reset values:
  - state = IDLE, owner = 0, rr_ptr = `NUM_INPUTS-1` (input 0 has first priority)
  - credits = `FLIT_BUFFER_DEPTH`, credit_err = 0
  - grant = 0, send_out = 0, sel = 0, locked = 0
- `has_credit` = (credits != 0).
- IDLE:
  - If `has_credit` and `|req`, grant the first requesting input scanning rr_ptr+1, rr_ptr+2, … modulo `NUM_INPUTS`.
  - If the granted flit is not a tail: next state = LOCKED and owner = winner.
  - If it is a tail (single-flit packet): stay IDLE.
  - In both cases rr_ptr ← winner on the grant cycle.
- LOCKED:
  - grant[owner] = `req[owner] & has_credit`. All other inputs are blocked, even if the owner stalls.
  - When a tail flit from the owner is transferred: next state = IDLE. rr_ptr is already equal to owner.
  - If req[owner] drops mid-packet: hold LOCKED with no grant.
- Credit update each cycle: credits ← credits − `send_out` + `credit_in`.
  - `send_out` and `credit_in` in the same cycle: credits unchanged.
  - `credit_in` with credits = `FLIT_BUFFER_DEPTH` and no send: credits stays at `FLIT_BUFFER_DEPTH` and credit_err ← 1. credit_err stays set until reset.
  - `send_out` is never issued with credits = 0, so credits never underflows.
- A credit that arrives while credits = 0 can be used in the following cycle, not in the same cycle.

## Timing
- `grant`, `sel` and `send_out` are combinational from `req`, `req_is_tail` and registered state. There is zero-cycle latency from req to grant when arbitration is free.
- `credits`, `locked` and `credit_err` are registered. They update on the `clk_noc` rising edge after the event.
- Credit loop: a flit sent at cycle t shows in `credits` at t+1. A credit_in at t allows a send at t+1 at the earliest.
- Back-to-back packets: a tail transfer at t allows a new arbitration winner, including a different input, at t+1. There is no bubble.
- Reset asserted mid-packet:
  - Outputs go to their reset values immediately (asynchronous).
  - Lock, rr_ptr and credits reset; any partial packet is abandoned.
  - After deassertion the first grant is possible on the first clock edge at which `rst_n` is high.

## Test plan
- Reset, then req = 5'b00001 with tail = 1 for one cycle. Required: grant = 00001 in that cycle, sel = 0, credits = 3 the next cycle, locked stays 0.
- From reset, req = 5'b10110 held, all single-flit, plus one credit_in per send. Required grant order 00010, 00100, 10000, 00010, …, with no repeat before every requester has been served.
- Input 2 sends a 4-flit packet, tail on flit 4, while input 1 requests continuously. Required:
  - grant = 00100 for 4 cycles, locked = 1 during flits 2–4.
  - Input 1 is granted in the cycle after the tail.
- No credit_in, 6 single-flit requests from input 0. Required:
  - 4 sends, then credits = 0 and grant = 0.
  - A credit_in pulse at cycle t gives exactly one send at t+1.
- send_out and credit_in in the same cycle with credits = 2: credits stays 2. credit_in with credits = 4 and no send: credits stays 4 and credit_err = 1 until reset.
- Assert rst_n low during flit 2 of a 3-flit packet. Required:
  - grant = 0, locked = 0, credits = 4 immediately.
  - After release, input 0 wins first when all inputs request.

Source files
------------

// File: rtl/noc_output_allocator.sv
// Round-robin output-port allocator with wormhole lock and downstream credit tracking.
// Grants are combinational from requests and registered state; credits, lock and error flag are registered.
module noc_output_allocator #(
    parameter int NUM_INPUTS        = 5,
    parameter int FLIT_BUFFER_DEPTH = 4,
    parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1),
    parameter int SEL_WIDTH         = $clog2(NUM_INPUTS)
) (
    input  logic                    clk_noc,
    input  logic                    rst_n,
    input  logic [NUM_INPUTS-1:0]   req,
    input  logic [NUM_INPUTS-1:0]   req_is_tail,
    input  logic                    credit_in,
    output logic [NUM_INPUTS-1:0]   grant,
    output logic [SEL_WIDTH-1:0]    sel,
    output logic                    send_out,
    output logic [CREDIT_WIDTH-1:0] credits,
    output logic                    locked,
    output logic                    credit_err
);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    localparam logic [CREDIT_WIDTH-1:0] LP_FULL    = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
    localparam logic [CREDIT_WIDTH-1:0] LP_ONE     = CREDIT_WIDTH'(1);
    localparam logic [SEL_WIDTH-1:0]    LP_RR_INIT = SEL_WIDTH'(NUM_INPUTS - 1);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [SEL_WIDTH-1:0]    r_owner;
    logic [SEL_WIDTH-1:0]    w_next_owner;
    logic [SEL_WIDTH-1:0]    r_rr_ptr;
    logic [SEL_WIDTH-1:0]    w_next_rr_ptr;
    logic [SEL_WIDTH-1:0]    r_sel;
    logic [CREDIT_WIDTH-1:0] r_credits;
    logic                    r_credit_err;

    logic                    w_has_credit;
    logic                    w_arb_found;
    logic [SEL_WIDTH-1:0]    w_arb_winner;
    logic [SEL_WIDTH-1:0]    w_idx;
    logic [NUM_INPUTS-1:0]   w_grant;
    logic [SEL_WIDTH-1:0]    w_sel;
    logic                    w_send;

    assign w_has_credit = (r_credits != '0);

    // Round-robin scan starting just after the last winner.
    always_comb begin
        w_arb_found  = 1'b0;
        w_arb_winner = '0;
        w_idx        = '0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            w_idx = SEL_WIDTH'((int'(r_rr_ptr) + k) % NUM_INPUTS);
            if (!w_arb_found && req[w_idx]) begin
                w_arb_found  = 1'b1;
                w_arb_winner = w_idx;
            end
        end
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_rr_ptr     <= LP_RR_INIT;
            r_sel        <= '0;
            r_credits    <= LP_FULL;
            r_credit_err <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_owner  <= w_next_owner;
            r_rr_ptr <= w_next_rr_ptr;
            r_sel    <= w_sel;
            if (w_send && !credit_in) begin
                r_credits <= r_credits - LP_ONE;
            end else if (credit_in && !w_send) begin
                // A surplus credit is dropped and remembered as a protocol error.
                if (r_credits == LP_FULL) begin
                    r_credit_err <= 1'b1;
                end else begin
                    r_credits <= r_credits + LP_ONE;
                end
            end
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_owner  = r_owner;
        w_next_rr_ptr = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_has_credit && w_arb_found) begin
                    w_next_rr_ptr = w_arb_winner;
                    if (!req_is_tail[w_arb_winner]) begin
                        w_next_state = ST_LOCKED;
                        w_next_owner = w_arb_winner;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_has_credit && req[r_owner] && req_is_tail[r_owner]) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held so a pending request cannot slip through.
    always_comb begin
        w_grant = '0;
        w_sel   = r_sel;
        if (rst_n) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_has_credit && w_arb_found) begin
                        w_grant[w_arb_winner] = 1'b1;
                        w_sel                 = w_arb_winner;
                    end
                end
                ST_LOCKED: begin
                    if (w_has_credit && req[r_owner]) begin
                        w_grant[r_owner] = 1'b1;
                        w_sel            = r_owner;
                    end
                end
                default: w_grant = '0;
            endcase
        end
    end

    assign w_send     = |w_grant;
    assign grant      = w_grant;
    assign sel        = w_sel;
    assign send_out   = w_send;
    assign credits    = r_credits;
    assign locked     = (r_state == ST_LOCKED);
    assign credit_err = r_credit_err;

endmodule
